// File: rtl/comp_max_min.sv
// Tracks max/min/count of a 4-bit sample burst using one shared external comparator; 3 cycles per sample.
// Backpressure: dado_rdy only in ESPERA. Optional tie counter enabled by `COMP_MAX_MIN_IGUAIS_EN`.
module comp_max_min #(
  parameter int N_CONT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        dado,
  input  logic              dado_val,
  input  logic              dado_ult,
  output logic              dado_rdy,
  output logic [3:0]        cmp_x,
  output logic [3:0]        cmp_y,
  input  logic              cmp_ma,
  input  logic              cmp_me,
  input  logic              cmp_ig,
  output logic [3:0]        maior,
  output logic [3:0]        menor,
  output logic [N_CONT-1:0] cont,
  output logic [N_CONT-1:0] iguais,
  output logic              ocupado,
  output logic              pronto
);

  typedef enum logic [2:0] {OCIOSO, ESPERA, CMP_MAX, CMP_MIN, FIM} state_t;

  localparam logic [N_CONT-1:0] CONT_MAX = '1;
  localparam logic [N_CONT-1:0] CONT_ONE = N_CONT'(1);

  state_t     state, state_nxt;
  logic [3:0] amostra;
  logic       ult;
  logic       prim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OCIOSO;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dado_rdy  = 1'b0;
    cmp_x     = 4'd0;
    cmp_y     = 4'd0;
    pronto    = 1'b0;
    ocupado   = (state != OCIOSO);
    case (state)
      OCIOSO: if (start) state_nxt = ESPERA;
      ESPERA: begin
        dado_rdy = 1'b1;
        if (dado_val) state_nxt = CMP_MAX;
      end
      CMP_MAX: begin
        cmp_x     = amostra;
        cmp_y     = maior;
        state_nxt = CMP_MIN;
      end
      CMP_MIN: begin
        cmp_x     = amostra;
        cmp_y     = menor;
        state_nxt = ult ? FIM : ESPERA;
      end
      FIM: begin
        pronto    = 1'b1;
        state_nxt = OCIOSO;
      end
      default: state_nxt = OCIOSO;
    endcase
  end

  // The first sample seeds both extremes so its own compares only report equality.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      amostra <= 4'd0;
      ult     <= 1'b0;
      prim    <= 1'b1;
      maior   <= 4'd0;
      menor   <= 4'd0;
      cont    <= '0;
    end else begin
      case (state)
        OCIOSO: begin
          if (start) begin
            cont <= '0;
            prim <= 1'b1;
          end
        end
        ESPERA: begin
          if (dado_val) begin
            amostra <= dado;
            ult     <= dado_ult;
            if (cont != CONT_MAX) cont <= cont + CONT_ONE;
            if (prim) begin
              maior <= dado;
              menor <= dado;
              prim  <= 1'b0;
            end
          end
        end
        CMP_MAX: if (cmp_ma) maior <= amostra;
        CMP_MIN: if (cmp_me) menor <= amostra;
        default: ;
      endcase
    end
  end

`ifdef COMP_MAX_MIN_IGUAIS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iguais <= '0;
    end else if (state == OCIOSO && start) begin
      iguais <= '0;
    end else if (state == CMP_MAX) begin
      if (cmp_ma)                             iguais <= CONT_ONE;
      else if (cmp_ig && iguais != CONT_MAX)  iguais <= iguais + CONT_ONE;
    end
  end
`else
  logic ig_unused;
  assign ig_unused = cmp_ig;
  assign iguais    = '0;
`endif

endmodule

// File: tb/tb_comp_max_min.sv
// Randomized bench for comp_max_min with a behavioural comparator and a queue-based reference model.
`timescale 1ns/1ps
module tb_comp_max_min;
  localparam int N_CONT = 8;
  localparam int SAT    = 255;
`ifdef COMP_MAX_MIN_IGUAIS_EN
  localparam bit IG_EN = 1'b1;
`else
  localparam bit IG_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, dado_val = 1'b0, dado_ult = 1'b0;
  logic [3:0] dado = 4'd0;
  logic dado_rdy, ocupado, pronto, cmp_ma, cmp_me, cmp_ig;
  logic [3:0] cmp_x, cmp_y, maior, menor;
  logic [N_CONT-1:0] cont, iguais;

  always #5 clk = ~clk;

  assign cmp_ma = (cmp_x > cmp_y);
  assign cmp_me = (cmp_x < cmp_y);
  assign cmp_ig = (cmp_x == cmp_y);

  comp_max_min #(.N_CONT(N_CONT)) dut (
    .clk(clk), .rst(rst), .start(start), .dado(dado), .dado_val(dado_val),
    .dado_ult(dado_ult), .dado_rdy(dado_rdy), .cmp_x(cmp_x), .cmp_y(cmp_y),
    .cmp_ma(cmp_ma), .cmp_me(cmp_me), .cmp_ig(cmp_ig), .maior(maior),
    .menor(menor), .cont(cont), .iguais(iguais), .ocupado(ocupado), .pronto(pronto)
  );

  int checks = 0, passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: samples of the current burst and the results of the last finished one.
  int q[$];
  int stim[$];
  bit m_busy = 0, have_acc = 0, m_last = 0;
  int m_cnt = 0, last_acc = 0, cyc = 0, m_max = 0, m_min = 0, m_ig = 0;
  bit p_start = 0, p_acc = 0, p_ult = 0;
  int p_dado = 0;

  function automatic int qmax(input int n);
    int r = 0;
    for (int i = 0; i < n; i++) if (q[i] > r) r = q[i];
    return r;
  endfunction

  function automatic int qmin(input int n);
    int r = 15;
    for (int i = 0; i < n; i++) if (q[i] < r) r = q[i];
    return r;
  endfunction

  function automatic int qties(input int n);
    int r = 0;
    int mx;
    mx = qmax(n);
    for (int i = 0; i < n; i++) if (q[i] == mx) r++;
    return (r > SAT) ? SAT : r;
  endfunction

  always @(negedge clk) begin
    int d, n, ey, eig;
    bit e_pronto, e_cmp, e_rdy;
    if (rst) begin
      q.delete();
      m_busy = 0; have_acc = 0; m_last = 0; m_cnt = 0;
      m_max = 0; m_min = 0; m_ig = 0;
      p_start = 0; p_acc = 0; p_ult = 0;
    end else begin
      cyc++;
      if (p_start) begin
        m_busy = 1; have_acc = 0; m_last = 0; m_cnt = 0; q.delete();
      end
      if (p_acc) begin
        q.push_back(p_dado);
        if (m_cnt < SAT) m_cnt++;
        have_acc = 1; last_acc = cyc; m_last = p_ult;
      end
      n = q.size();
      d = cyc - last_acc;
      e_pronto = m_busy && have_acc && m_last && (d == 2);
      e_cmp    = m_busy && have_acc && (d < 2);
      e_rdy    = m_busy && !e_pronto && (!have_acc || d >= 2);
      chk("ocupado", ocupado, m_busy);
      chk("dado_rdy", dado_rdy, e_rdy);
      chk("pronto", pronto, e_pronto);
      chk("cont", cont, m_cnt);
      chk("cmp_x", cmp_x, e_cmp ? q[n-1] : 0);
      ey = 0;
      if (e_cmp) begin
        if (n == 1)      ey = q[0];
        else if (d == 0) ey = qmax(n - 1);
        else             ey = qmin(n - 1);
      end
      chk("cmp_y", cmp_y, ey);
      if (m_busy && have_acc && d >= 2) begin
        chk("maior", maior, qmax(n));
        chk("menor", menor, qmin(n));
        eig = IG_EN ? qties(n) : 0;
        chk("iguais", iguais, eig);
      end else if (!m_busy || !have_acc) begin
        chk("maior_held", maior, m_max);
        chk("menor_held", menor, m_min);
        chk("iguais_idle", iguais, (IG_EN && !m_busy) ? m_ig : 0);
      end
      p_start = !m_busy && start;
      p_acc   = dado_val && dado_rdy;
      p_dado  = dado;
      p_ult   = dado_ult;
      if (e_pronto) begin
        m_max = qmax(n); m_min = qmin(n); m_ig = IG_EN ? qties(n) : 0;
        m_busy = 0;
      end
    end
  end

  task automatic run_burst(input int maxgap, input bit noise);
    int g, k;
    bit acc, r, found;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    foreach (stim[i]) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      if (g > 0) begin
        dado_val = 1'b0;
        repeat (g) begin
          @(posedge clk); #1;
          if (noise) start = 1'($urandom_range(1, 0));
        end
      end
      dado     = stim[i][3:0];
      dado_ult = (i == stim.size() - 1);
      dado_val = 1'b1;
      acc = 0;
      for (k = 0; k < 40 && !acc; k++) begin
        @(negedge clk); r = dado_rdy;
        @(posedge clk); #1;
        if (r) acc = 1;
        else if (noise) start = 1'($urandom_range(1, 0));
      end
      start = 1'b0;
      if (!acc) begin
        chk("accept_timeout", 0, 1);
        dado_val = 1'b0; dado_ult = 1'b0;
        return;
      end
    end
    dado_val = 1'b0; dado_ult = 1'b0;
    found = 0;
    for (k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (pronto) found = 1;
    end
    chk("pronto_seen", found, 1);
    if (found) chk("pronto_latency", k, 3);
    @(posedge clk); #1;
  endtask

  initial begin
    int len;
    repeat (2) @(negedge clk);
    chk("rst_maior", maior, 0);   chk("rst_menor", menor, 0);
    chk("rst_cont", cont, 0);     chk("rst_iguais", iguais, 0);
    chk("rst_pronto", pronto, 0); chk("rst_ocupado", ocupado, 0);
    chk("rst_rdy", dado_rdy, 0);  chk("rst_cmp_x", cmp_x, 0);
    chk("rst_cmp_y", cmp_y, 0);
    @(posedge clk); #2 rst = 1'b0;

    stim = '{5, 9, 2, 9};
    run_burst(0, 0);
    chk("b1_maior", maior, 9); chk("b1_menor", menor, 2);
    chk("b1_cont", cont, 4);   chk("b1_iguais", iguais, IG_EN ? 2 : 0);

    stim = '{7};
    run_burst(0, 0);
    chk("b2_maior", maior, 7); chk("b2_menor", menor, 7);
    chk("b2_cont", cont, 1);   chk("b2_iguais", iguais, IG_EN ? 1 : 0);

    stim = '{15, 0, 8};
    run_burst(4, 0);
    chk("b3_maior", maior, 15); chk("b3_menor", menor, 0); chk("b3_cont", cont, 3);

    stim = '{3, 12, 6};
    run_burst(3, 1);
    chk("b4_maior", maior, 12); chk("b4_menor", menor, 3); chk("b4_cont", cont, 3);

    // Asynchronous reset while the first sample sits in CMP_MAX.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; dado = 4'd6; dado_val = 1'b1; dado_ult = 1'b0;
    @(posedge clk); #1 dado_val = 1'b0;
    chk("pre_rst_ocupado", ocupado, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_maior", maior, 0);   chk("arst_menor", menor, 0);
    chk("arst_cont", cont, 0);     chk("arst_iguais", iguais, 0);
    chk("arst_pronto", pronto, 0); chk("arst_ocupado", ocupado, 0);
    chk("arst_rdy", dado_rdy, 0);  chk("arst_cmp_x", cmp_x, 0);
    chk("arst_cmp_y", cmp_y, 0);
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;

    for (int b = 0; b < 6; b++) begin
      stim.delete();
      len = $urandom_range(10, 1);
      for (int i = 0; i < len; i++) stim.push_back($urandom_range(15, 0));
      run_burst(3, 1);
    end

    stim.delete();
    for (int i = 0; i < 300; i++) stim.push_back($urandom_range(15, 0));
    run_burst(0, 0);
    chk("sat_cont", cont, 255);

    stim.delete();
    for (int i = 0; i < 300; i++) stim.push_back(10);
    run_burst(0, 0);
    chk("eq_cont", cont, 255);
    chk("eq_iguais", iguais, IG_EN ? 255 : 0);
    chk("eq_maior", maior, 10); chk("eq_menor", menor, 10);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/comp_max_min.md
# comp_max_min

Sequential extreme-value tracker built around one external `comp4bits` 4-bit magnitude comparator, which it time-multiplexes. It accepts a burst of 4-bit samples over a valid/ready handshake. It drives the comparator operands and consumes the comparator's `ma`/`me`/`ig` flags. It keeps the running maximum, running minimum and sample count, and pulses `pronto` when the burst ends. It sits directly around `comp4bits` in the datapath: it feeds that block and consumes what it produces.

## Interface
- `N_CONT`, default 8: width of the sample counter `cont` and of the tie counter `iguais`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begins a burst; sampled only in OCIOSO.
- `dado` input 4: sample value.
- `dado_val` input 1: `dado` valid.
- `dado_ult` input 1: marks the current sample as the last of the burst; qualified by the handshake.
- `dado_rdy` output 1: block can accept a sample.
- `cmp_x` output 4: comparator operand X. Always the held sample.
- `cmp_y` output 4: comparator operand Y. `maior` or `menor`, depending on state.
- `cmp_ma` input 1: comparator flag, X > Y.
- `cmp_me` input 1: comparator flag, X < Y.
- `cmp_ig` input 1: comparator flag, X = Y.
- `maior` output 4: running maximum.
- `menor` output 4: running minimum.
- `cont` output N_CONT: accepted sample count, saturating.
- `iguais` output N_CONT: count of samples equal to the current maximum (see Configuration).
- `ocupado` output 1: high in every state except OCIOSO.
- `pronto` output 1: one-cycle pulse at burst end.

## Operation
- States: OCIOSO, ESPERA, CMP_MAX, CMP_MIN, FIM.
- OCIOSO:
  - `start`=1 → ESPERA.
  - On that transition, clear `cont`, `iguais` and the first-sample flag `prim` (set `prim`=1).
  - `maior`/`menor` hold their previous burst results until the first sample of the new burst.
- ESPERA:
  - `dado_rdy`=1.
  - On `dado_val`=1: latch `dado` into `amostra` and latch `dado_ult`.
  - `cont` += 1, saturating at 2^N_CONT−1.
  - If `prim`=1: load `maior`=`menor`=`dado` and clear `prim`.
  - Then → CMP_MAX.
- CMP_MAX:
  - `cmp_x`=`amostra`, `cmp_y`=`maior`.
  - `cmp_ma`=1 → `maior`←`amostra`.
  - → CMP_MIN.
- CMP_MIN:
  - `cmp_x`=`amostra`, `cmp_y`=`menor`.
  - `cmp_me`=1 → `menor`←`amostra`.
  - Latched last flag = 1 → FIM; otherwise → ESPERA.
- FIM: `pronto`=1 for this one cycle, then → OCIOSO.
- `dado_rdy`=0 outside ESPERA. Upstream holds `dado`/`dado_val`/`dado_ult` stable until `dado_rdy`=1.
- `start` is ignored outside OCIOSO. `dado_val` is ignored outside ESPERA.
- The comparator is purely combinational. Its flags are sampled in the same cycle that the operands are driven.
- In OCIOSO, ESPERA and FIM: `cmp_x`=`cmp_y`=0.
- A first sample compares equal to itself in both compare states. The flag `cmp_ig`=1 is the only effect.
- Contradictory flags (more than one of `cmp_ma`/`cmp_me`/`cmp_ig` high) never occur with `comp4bits`. Priority is `ma` over `ig` in CMP_MAX.

## Timing
- Reset values: state=OCIOSO, `maior`=0, `menor`=0, `cont`=0, `iguais`=0, `pronto`=0, `ocupado`=0, `dado_rdy`=0, `cmp_x`=0, `cmp_y`=0, `amostra`=0, `prim`=1.
- Reset mid-burst aborts immediately. No `pronto` is produced.
- Throughput: one sample per 3 cycles (ESPERA → CMP_MAX → CMP_MIN).
- Latency: `pronto` is high in the 3rd cycle after the clock edge that accepts the last sample.
- `maior`/`menor` are final from the edge that leaves CMP_MIN. They are stable while `pronto`=1 and held until the next burst's first sample.
- `cont` saturates: 255 accepts stay 255 for `N_CONT`=8. `iguais` saturates the same way.

## Configuration
- Macro: `COMP_MAX_MIN_IGUAIS_EN`.
- Defined:
  - In CMP_MAX, `cmp_ma`=1 sets `iguais`←1.
  - In CMP_MAX, `cmp_ig`=1 increments `iguais`, saturating.
  - `iguais` is cleared on the OCIOSO → ESPERA transition.
- Undefined: the counter logic is absent and `iguais` is tied to 0.

## Test plan
- Reset: assert `rst` asynchronously mid-CMP_MAX → all outputs take their reset values without waiting for a clock edge; `dado_rdy`=0.
- Burst 5, 9, 2, 9 (last), with `dado_val` held high → `maior`=9, `menor`=2, `cont`=4, `pronto` exactly one cycle, 3 cycles after the 4th accept; with the macro, `iguais`=2.
- Single sample 7 with `dado_ult`=1 → `maior`=`menor`=7, `cont`=1, `iguais`=1 (macro on) or 0 (macro off).
- Bursty `dado_val` (gaps of 0–4 cycles) on 0xF, 0x0, 0x8 → `maior`=F, `menor`=0; `dado_rdy` high only in ESPERA; no sample dropped or duplicated.
- `start` pulsed during a burst and `dado_val` high outside ESPERA → no effect; the next burst after `pronto` clears `cont` and replaces the old `maior`/`menor`.
- 300 samples with `N_CONT`=8 → `cont`=255 (saturated); an all-equal stream gives `iguais`=255.
